// File: rtl/data_mem.sv
// Byte-addressed data memory for the MEM stage: masked sub-word stores, extending loads,
// alignment faults, a registered 1-cycle read and a post-reset clear sweep.
module data_mem #(
  parameter int ADDR_WIDTH     = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault,
  output logic                  busy
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_clr_idx;
  logic               r_ready;
  logic               r_busy;
  logic               r_vld_p1;
  logic [31:0]        r_rdata_p1;
  logic               r_fault_p1;
  logic [31:0]        r_mem [DEPTH];

  logic [IDX_W-1:0]   w_idx;
  logic [1:0]         w_lane;
  logic               w_accept;
  logic               w_fault;
  logic               w_store;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [31:0]        w_rword;

  function automatic logic is_fault(input logic [1:0] size, input logic [1:0] lane);
    return (size == 2'd3) || (size == 2'd1 && lane[0]) || (size == 2'd2 && lane != 2'd0);
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    return 4'b0001 << lane;
      2'd1:    return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the low store bits across the word so the lane mask alone picks the target bytes.
  function automatic logic [31:0] store_data(input logic [31:0] wdata, input logic [1:0] size);
    case (size)
      2'd0:    return {4{wdata[7:0]}};
      2'd1:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = $signed(word[{lane, 3'b000} +: 8]);
    h = $signed(word[{lane[1], 4'b0000} +: 16]);
    case (size)
      2'd0:    return uns ? {24'd0, b} : 32'(b);
      2'd1:    return uns ? {16'd0, h} : 32'(h);
      default: return word;
    endcase
  endfunction

  assign w_idx    = req_addr[ADDR_WIDTH-1:2];
  assign w_lane   = req_addr[1:0];
  assign w_accept = req_valid && r_ready && !reset;
  assign w_fault  = is_fault(req_size, w_lane);
  assign w_store  = w_accept && req_write && !w_fault;
  assign w_be     = lane_mask(req_size, w_lane);
  assign w_wdata  = store_data(req_wdata, req_size);
  assign w_rword  = r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      r_clr_idx  <= '0;
      r_ready    <= !CLEAR_ON_RESET;
      r_busy     <= CLEAR_ON_RESET;
      r_vld_p1   <= 1'b0;
      r_rdata_p1 <= '0;
      r_fault_p1 <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == IDX_W'(DEPTH - 1)) begin
            r_state <= S_READY;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: ;
      endcase
      // p0 -> p1: accepted request becomes next cycle's response
      r_vld_p1 <= w_accept;
      if (w_accept) begin
        r_fault_p1 <= w_fault;
        r_rdata_p1 <= (req_write || w_fault) ? 32'd0
                      : extract_load(w_rword, req_size, w_lane, req_unsigned);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_clr_idx] <= '0;
      end else if (w_store) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready  = r_ready;
  assign busy       = r_busy;
  assign resp_valid = r_vld_p1;
  assign resp_rdata = r_rdata_p1;
  assign resp_fault = r_fault_p1;

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem (ADDR_WIDTH=6): byte-array reference model, expectation queue and
// a monitor that pops one expectation per presented response.
module tb_data_mem;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [5:0]  req_addr = 6'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        busy;

  data_mem #(.ADDR_WIDTH(6), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        flt;
    int          due;
    string       name;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mem_m [64];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) mem_m[i] = 8'd0;
  endfunction

  // Reference behaviour: byte array, n = 2**size bytes starting at the byte address.
  function automatic void model(input bit wr, input logic [1:0] sz, input bit uns, input int a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic flt);
    int     n;
    longint v;
    flt = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    rd  = 32'd0;
    if (flt) return;
    n = 1 << sz;
    if (wr) begin
      for (int i = 0; i < n; i++) mem_m[a + i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(mem_m[a + i]) << (8 * i);
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      rd = v[31:0];
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // Presents a request, waits (bounded) for ready, records the expected response.
  task automatic issue(input string nm, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [5:0] a, input logic [31:0] wd);
    int   w;
    exp_t e;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL %s handshake: ready=%0b expected 1 within 200 cycles", nm, req_ready);
    end else begin
      model(wr, sz, uns, int'(a), wd, e.rd, e.flt);
      e.due  = cyc + 1;
      e.name = nm;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    idle();
    w = 0;
    while (q.size() != 0 && w < 50) begin
      w++;
      @(negedge clk);
    end
    chk("drain_pending", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    idle();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", req_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic count_clear(input string nm);
    int n;
    int rdy_bad;
    n = 0;
    rdy_bad = 0;
    @(negedge clk);
    while (busy && n < 1000) begin
      if (req_ready) rdy_bad++;
      n++;
      @(negedge clk);
    end
    chk({nm, "_busy_cycles"}, n, 16);
    chk({nm, "_ready_during_clear"}, rdy_bad, 0);
    chk({nm, "_ready_after"}, req_ready, 1);
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic dump();
    for (int w = 0; w < 16; w++) begin
      if (dut.r_mem[w] != 32'd0) $display("dump addr 0x%02h : 0x%08h", w * 4, dut.r_mem[w]);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due < cyc) begin
      total++; bad++;
      $display("FAIL %s latency: no response at cycle %0d, expected at %0d", q[0].name, cyc, q[0].due);
      void'(q.pop_front());
    end
    if (resp_valid) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp: resp_valid=1 rdata=0x%08h expected no response", resp_rdata);
      end else begin
        e = q.pop_front();
        if (cyc != e.due || resp_rdata !== e.rd || resp_fault !== e.flt) begin
          bad++;
          $display("FAIL %s: got rdata=0x%08h fault=%0b cycle=%0d expected rdata=0x%08h fault=%0b cycle=%0d",
                   e.name, resp_rdata, resp_fault, cyc, e.rd, e.flt, e.due);
        end
      end
    end
  end

  initial begin
    model_clear();
    pulse_reset();
    count_clear("clear0");
    issue("lw_3c_after_clear", 1'b0, 2'd2, 1'b0, 6'h3C, 32'd0);

    issue("sw_08", 1'b1, 2'd2, 1'b0, 6'h08, 32'h11223344);
    issue("sb_09", 1'b1, 2'd0, 1'b0, 6'h09, 32'h000000AA);
    issue("lw_08_merged", 1'b0, 2'd2, 1'b0, 6'h08, 32'd0);

    issue("sw_10", 1'b1, 2'd2, 1'b0, 6'h10, 32'h000080F0);
    issue("lb_10", 1'b0, 2'd0, 1'b0, 6'h10, 32'd0);
    issue("lbu_10", 1'b0, 2'd0, 1'b1, 6'h10, 32'd0);
    issue("lh_10", 1'b0, 2'd1, 1'b0, 6'h10, 32'd0);
    issue("lhu_10", 1'b0, 2'd1, 1'b1, 6'h10, 32'd0);
    issue("lbu_11", 1'b0, 2'd0, 1'b1, 6'h11, 32'd0);

    issue("sw_04", 1'b1, 2'd2, 1'b0, 6'h04, 32'h55667788);
    issue("sh_05_fault", 1'b1, 2'd1, 1'b0, 6'h05, 32'h0000BEEF);
    issue("lw_06_fault", 1'b0, 2'd2, 1'b0, 6'h06, 32'd0);
    issue("size3_fault", 1'b1, 2'd3, 1'b0, 6'h00, 32'hFFFFFFFF);
    issue("lw_04_unchanged", 1'b0, 2'd2, 1'b0, 6'h04, 32'd0);

    issue("sw_20", 1'b1, 2'd2, 1'b0, 6'h20, 32'hDEADBEEF);
    issue("lw_20_b2b", 1'b0, 2'd2, 1'b0, 6'h20, 32'd0);
    issue("sh_22", 1'b1, 2'd1, 1'b0, 6'h22, 32'h00001234);
    issue("lw_20_half", 1'b0, 2'd2, 1'b0, 6'h20, 32'd0);
    drain();

    // Reset five cycles into a clear restarts the sweep.
    pulse_reset();
    repeat (5) @(negedge clk);
    chk("midclear_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    count_clear("clear_restart");
    issue("lw_08_cleared", 1'b0, 2'd2, 1'b0, 6'h08, 32'd0);
    issue("sw_20_again", 1'b1, 2'd2, 1'b0, 6'h20, 32'hCAFEF00D);
    drain();

    // Load presented together with reset: no response; the held request waits out the clear.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 6'h20;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("inflight_resp_valid", resp_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    issue("lw_20_after_inflight_reset", 1'b0, 2'd2, 1'b0, 6'h20, 32'd0);

    for (int i = 0; i < 300; i++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            6'($urandom_range(0, 63)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
    end
    drain();
    dump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
